// File: rtl/vga_capture_monitor.sv
// rtl/vga_capture_monitor.sv - VGA stream receiver: timing recovery, lock tracking, pixel stream, frame checksum
module vga_capture_monitor #(
  parameter int H_BACK   = 91,
  parameter int H_ACTIVE = 1220,
  parameter int V_BACK   = 32,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        r_in,
  input  logic        g_in,
  input  logic        b_in,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic [10:0] line_len,
  output logic [7:0]  hsync_width,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [7:0]  err_count
);

  localparam logic [10:0] H_START = 11'(H_BACK);
  localparam logic [10:0] H_END   = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_BACK);
  localparam logic [9:0]  V_END   = 10'(V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCK} state_t;

  state_t      state, state_nxt;
  logic [4:0]  s1;
  logic [1:0]  s2;
  logic        h_fall, h_rise, v_rise;
  logic [10:0] hc, hx, hx_cur, line_len_nxt;
  logic [7:0]  wc;
  logic [9:0]  vl, fl, fl_cap;
  logic        v_pend, line_err, first_fall, timeout;
  logic [20:0] ref_q, result;
  logic        match, ref_load, err_inc, frame_ok;
  logic        h_act, v_act, pv;
  logic [15:0] sum;

  // s1 = {hsync, vsync, r, g, b}; only the syncs need a second stage for edges
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      s1 <= 5'b11000;
      s2 <= 2'b11;
    end else begin
      s1 <= {hsync_in, vsync_in, r_in, g_in, b_in};
      s2 <= s1[4:3];
    end
  end

  assign h_fall = !s1[4] && s2[1];
  assign h_rise = s1[4] && !s2[1];
  assign v_rise = s1[3] && !s2[0];

  assign timeout      = (hc == 11'd2047);
  assign line_len_nxt = hc + 11'd1;
  assign hx_cur       = h_rise ? 11'd0 : (hx == 11'd2047 ? hx : hx + 11'd1);
  assign fl_cap       = (h_rise && fl != 10'd1023) ? fl + 10'd1 : fl;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      hc          <= '0;
      wc          <= '0;
      hx          <= '0;
      vl          <= '0;
      fl          <= '0;
      v_pend      <= 1'b0;
      line_len    <= '0;
      hsync_width <= '0;
      frame_lines <= '0;
    end else begin
      if (h_fall) begin
        hc       <= '0;
        line_len <= line_len_nxt;
      end else if (!timeout) begin
        hc <= hc + 11'd1;
      end
      if (h_rise) begin
        hsync_width <= wc;
        wc          <= '0;
      end else if (!s1[4] && wc != 8'd255) begin
        wc <= wc + 8'd1;
      end
      hx <= hx_cur;
      // a rise coinciding with the vsync rise still counts for the old frame
      if (h_rise) vl <= v_pend ? 10'd0 : (vl == 10'd1023 ? vl : vl + 10'd1);
      if (v_rise) v_pend <= 1'b1;
      else if (h_rise) v_pend <= 1'b0;
      if (v_rise) begin
        frame_lines <= fl_cap;
        fl          <= '0;
      end else begin
        fl <= fl_cap;
      end
    end
  end

  // the first fall of a frame follows the vertical interval and is not compared
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      line_err   <= 1'b0;
      first_fall <= 1'b1;
    end else if (v_rise) begin
      line_err   <= 1'b0;
      first_fall <= 1'b1;
    end else if (h_fall) begin
      first_fall <= 1'b0;
      if (!first_fall && line_len_nxt != line_len) line_err <= 1'b1;
    end
  end

  assign result = {fl_cap, line_len};
  assign match  = (result == ref_q);

  always_ff @(posedge clk48) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ref_load  = 1'b0;
    err_inc   = 1'b0;
    frame_ok  = 1'b0;
    if (timeout) begin
      state_nxt = SEARCH;
      err_inc   = (state == LOCK);
    end else if (v_rise) begin
      case (state)
        SEARCH: state_nxt = MEASURE;
        MEASURE: begin
          if (!line_err) begin
            ref_load  = 1'b1;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (!line_err && match) begin
            state_nxt = LOCK;
          end else begin
            ref_load  = 1'b1;
            state_nxt = line_err ? MEASURE : VERIFY;
          end
        end
        LOCK: begin
          if (!line_err && match) begin
            frame_ok = 1'b1;
          end else begin
            err_inc   = 1'b1;
            ref_load  = !line_err;
            state_nxt = line_err ? MEASURE : VERIFY;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = 1'b0;
    if (state == LOCK) locked = 1'b1;
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      ref_q     <= '0;
      err_count <= '0;
    end else begin
      if (ref_load) ref_q <= result;
      if (err_inc && err_count != 8'd255) err_count <= err_count + 8'd1;
    end
  end

  assign h_act = (hx_cur >= H_START) && (hx_cur < H_END);
  assign v_act = (vl >= V_START) && (vl < V_END);
  assign pv    = h_act && v_act && locked;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= pv;
      if (pv) begin
        pix_x   <= hx_cur - H_START;
        pix_y   <= vl - V_START;
        pix_rgb <= s1[2:0];
      end
    end
  end

  // sum covers exactly the pixels emitted since the previous vsync rise
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      sum        <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_ok;
      if (frame_ok) frame_sum <= sum;
      if (v_rise)  sum <= '0;
      else if (pv) sum <= sum + {13'd0, s1[2:0]};
    end
  end

endmodule

// File: tb/tb_vga_capture_monitor.sv
// tb/tb_vga_capture_monitor.sv - directed bench for vga_capture_monitor on a reduced 40x12 raster
module tb_vga_capture_monitor;

  localparam int HT = 40, HS_START = 28, HS_END = 34, H_ACT = 24;
  localparam int VT = 12, VS_START = 8, VS_END = 10, V_ACT = 6;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in, r_in, g_in, b_in;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [2:0]  pix_rgb;
  logic [10:0] line_len;
  logic [7:0]  hsync_width;
  logic [9:0]  frame_lines;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int gh = 0, gv = 0, lh = 0, lv = 0;
  int pattern = 0, short_line = -1, px_x = 0, px_y = 0;
  int pv_count = 0, white_count = 0, fd_count = 0;
  int wx = -1, wy = -1;

  vga_capture_monitor #(.H_BACK(6), .H_ACTIVE(24), .V_BACK(1), .V_ACTIVE(6)) dut (
    .clk48(clk48), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .line_len(line_len), .hsync_width(hsync_width), .frame_lines(frame_lines),
    .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum),
    .err_count(err_count)
  );

  always #5 clk48 = ~clk48;

  always @(negedge clk48) begin
    if (pix_valid) begin
      pv_count++;
      if (pix_rgb == 3'd7) begin
        white_count++;
        wx = int'(pix_x);
        wy = int'(pix_y);
      end
    end
    if (frame_done) fd_count++;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic white;
    int   line_end;
    @(negedge clk48);
    hsync_in = !(gh >= HS_START && gh < HS_END);
    vsync_in = !(gv >= VS_START && gv < VS_END);
    white = (gh < H_ACT && gv < V_ACT) &&
            (pattern == 1 || (pattern == 2 && gh == px_x && gv == px_y));
    {r_in, g_in, b_in} = white ? 3'b111 : 3'b000;
    lh = gh;
    lv = gv;
    line_end = (gv == short_line) ? HT - 2 : HT - 1;
    if (gh >= line_end) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
  endtask

  task automatic run_frame(input int pat);
    pattern = pat;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      if (gh == 0 && gv == 0) break;
    end
  endtask

  task automatic run_to(input int v, input int h, input int pat);
    pattern = pat;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      if (lv == v && lh == h) break;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk48);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      {r_in, g_in, b_in} = 3'b000;
    end
  endtask

  task automatic clear_mon();
    pv_count = 0;
    white_count = 0;
    fd_count = 0;
    wx = -1;
    wy = -1;
  endtask

  function automatic logic [95:0] all_out();
    return 96'({pix_valid, pix_x, pix_y, pix_rgb, line_len, hsync_width,
                frame_lines, locked, frame_done, frame_sum, err_count});
  endfunction

  initial begin
    rst_n = 1'b0;
    idle(4);
    check("reset_outputs", all_out(), 96'(0));
    rst_n = 1'b1;

    run_frame(0);
    run_frame(0);
    run_to(10, 0, 0);
    check("lock_before_rise3", 96'(locked), 96'(0));
    step();
    check("lock_lat1", 96'(locked), 96'(0));
    step();
    check("lock_lat2", 96'(locked), 96'(1));
    run_frame(0);

    clear_mon();
    run_frame(1);
    check("line_len", 96'(line_len), 96'(40));
    check("hsync_width", 96'(hsync_width), 96'(6));
    check("frame_lines", 96'(frame_lines), 96'(12));
    check("err_count_clean", 96'(err_count), 96'(0));
    check("pix_count_white", 96'(pv_count), 96'(144));
    check("white_count", 96'(white_count), 96'(144));
    check("frame_done_white", 96'(fd_count), 96'(1));
    check("frame_sum_white", 96'(frame_sum), 96'(16'h03F0));

    clear_mon();
    run_frame(0);
    check("frame_sum_black", 96'(frame_sum), 96'(0));
    check("frame_done_black", 96'(fd_count), 96'(1));

    px_x = 0; px_y = 0;
    clear_mon();
    run_frame(2);
    check("first_px_count", 96'(white_count), 96'(1));
    check("first_px_x", 96'(wx), 96'(0));
    check("first_px_y", 96'(wy), 96'(0));
    check("first_px_sum", 96'(frame_sum), 96'(7));

    px_x = 23; px_y = 5;
    clear_mon();
    run_frame(2);
    check("last_px_count", 96'(white_count), 96'(1));
    check("last_px_x", 96'(wx), 96'(23));
    check("last_px_y", 96'(wy), 96'(5));
    check("last_px_pixels", 96'(pv_count), 96'(144));
    check("last_px_done", 96'(fd_count), 96'(1));

    short_line = 3;
    clear_mon();
    run_frame(0);
    short_line = -1;
    check("glitch_err_count", 96'(err_count), 96'(1));
    check("glitch_locked", 96'(locked), 96'(0));
    check("glitch_no_done", 96'(fd_count), 96'(0));
    clear_mon();
    run_frame(0);
    check("glitch_plus1_locked", 96'(locked), 96'(0));
    check("glitch_plus1_pixels", 96'(pv_count), 96'(0));
    run_frame(0);
    check("glitch_relock", 96'(locked), 96'(1));

    idle(1900);
    check("sync_loss_early", 96'(locked), 96'(1));
    idle(200);
    check("sync_loss_locked", 96'(locked), 96'(0));
    check("sync_loss_err", 96'(err_count), 96'(2));
    check("sync_loss_pix", 96'(pix_valid), 96'(0));
    run_frame(0);
    run_frame(0);
    check("resync_rise2", 96'(locked), 96'(0));
    run_frame(0);
    check("resync_rise3", 96'(locked), 96'(1));

    run_to(2, 10, 1);
    check("pre_reset_pix", 96'(pix_valid), 96'(1));
    rst_n = 1'b0;
    step();
    check("mid_reset_outputs", all_out(), 96'(0));
    step();
    step();
    step();
    rst_n = 1'b1;
    run_frame(1);
    run_frame(0);
    check("post_reset_rise2", 96'(locked), 96'(0));
    clear_mon();
    run_frame(0);
    check("post_reset_rise3", 96'(locked), 96'(1));
    check("post_reset_err", 96'(err_count), 96'(0));
    check("post_reset_pixels", 96'(pv_count), 96'(0));
    clear_mon();
    run_frame(1);
    check("post_reset_sum", 96'(frame_sum), 96'(16'h03F0));
    check("post_reset_count", 96'(pv_count), 96'(144));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
